// File: rtl/display_timings_param.sv
// Parametrised raster timing generator with pixel clock-enable. Every output is registered
// from the next beam position, so position, syncs, flags and strobes are always coherent.
module display_timings_param #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int unsigned CORDW    = 10,
    parameter int unsigned FCW      = 16
) (
    input  logic             clk_pix_i,
    input  logic             rst_ni,
    input  logic             ce_i,
    output logic [CORDW-1:0] sx_o,
    output logic [CORDW-1:0] sy_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             de_o,
    output logic             hblank_o,
    output logic             vblank_o,
    output logic             line_o,
    output logic             frame_o,
    output logic [FCW-1:0]   frame_cnt_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] H_ACT_C  = CORDW'(H_ACTIVE);
    localparam logic [CORDW-1:0] V_ACT_C  = CORDW'(V_ACTIVE);
    localparam logic [CORDW-1:0] HS_BEG_C = CORDW'(H_ACTIVE + H_FP);
    localparam logic [CORDW-1:0] HS_END_C = CORDW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CORDW-1:0] VS_BEG_C = CORDW'(V_ACTIVE + V_FP);
    localparam logic [CORDW-1:0] VS_END_C = CORDW'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Reject degenerate timings and counters too narrow for the raster.
    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0)
    begin : g_bad_porch
        $error("display_timings_param: porch and sync widths must be non-zero");
    end
    if (H_TOTAL > (64'd1 << CORDW) || V_TOTAL > (64'd1 << CORDW)) begin : g_bad_cordw
        $error("display_timings_param: CORDW too small for H_TOTAL/V_TOTAL");
    end

    logic [CORDW-1:0] sx_q, sx_d;
    logic [CORDW-1:0] sy_q, sy_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic             hblank_q, hblank_d;
    logic             vblank_q, vblank_d;
    logic             line_q, line_d;
    logic             frame_q, frame_d;
    logic [FCW-1:0]   fcnt_q, fcnt_d;

    always_comb begin
        sx_d = sx_q;
        sy_d = sy_q;
        if (ce_i) begin
            if (sx_q == H_LAST) begin
                sx_d = '0;
                sy_d = (sy_q == V_LAST) ? '0 : sy_q + 1'b1;
            end else begin
                sx_d = sx_q + 1'b1;
            end
        end
    end

    // Decode from the next position so the registered flags line up with sx_q/sy_q.
    always_comb begin
        hsync_d  = ((sx_d >= HS_BEG_C) && (sx_d <= HS_END_C)) ? H_POL : ~H_POL;
        vsync_d  = ((sy_d >= VS_BEG_C) && (sy_d <= VS_END_C)) ? V_POL : ~V_POL;
        hblank_d = (sx_d >= H_ACT_C);
        vblank_d = (sy_d >= V_ACT_C);
        de_d     = ~hblank_d & ~vblank_d;
        line_d   = ce_i && (sx_d == '0);
        frame_d  = ce_i && (sx_d == '0) && (sy_d == '0);
        fcnt_d   = frame_d ? fcnt_q + 1'b1 : fcnt_q;
    end

    always_ff @(posedge clk_pix_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sx_q     <= H_LAST;
            sy_q     <= V_LAST;
            hsync_q  <= ~H_POL;
            vsync_q  <= ~V_POL;
            de_q     <= 1'b0;
            hblank_q <= 1'b1;
            vblank_q <= 1'b1;
            line_q   <= 1'b0;
            frame_q  <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            de_q     <= de_d;
            hblank_q <= hblank_d;
            vblank_q <= vblank_d;
            line_q   <= line_d;
            frame_q  <= frame_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign sx_o        = sx_q;
    assign sy_o        = sy_q;
    assign hsync_o     = hsync_q;
    assign vsync_o     = vsync_q;
    assign de_o        = de_q;
    assign hblank_o    = hblank_q;
    assign vblank_o    = vblank_q;
    assign line_o      = line_q;
    assign frame_o     = frame_q;
    assign frame_cnt_o = fcnt_q;

endmodule
